// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU with ASCII-string opcode decode.
//
// Results register one clock after the operands are sampled. A new operation
// is accepted on every clock, and no handshake is used.
//
// Ports:
//   clk     in   1      clock; all state updates on the rising edge
//   rst     in   1      synchronous, active-high reset; has priority over any op
//   c_out   out  1      registered carry out (arithmetic ops); 0 for logic ops
//   sum     out  WIDTH  registered result
//   op_err  out  1      registered; 1 when oper matches no legal opcode
//   zero    out  1      (ALU_FLAGS_EN only) registered sum==0
//   neg     out  1      (ALU_FLAGS_EN only) registered sum[WIDTH-1]
//   ovf     out  1      (ALU_FLAGS_EN only) registered two's-complement overflow
//   oper    in   OPW    ASCII opcode string, right-justified, upper bits zero
//   a, b    in   WIDTH  operands
//   c_in    in   1      carry in (arithmetic ops only)
//
// Configuration macro: ALU_FLAGS_EN adds the zero/neg/ovf flag outputs.
// When the macro is undefined, those flag ports and their logic are absent.

module alu_8bit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 82
) (
  input  logic             clk,
  input  logic             rst,
  output logic             c_out,
  output logic [WIDTH-1:0] sum,
  output logic             op_err,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             ovf,
`endif
  input  logic [OPW-1:0]   oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in
);

  // Opcodes are full-width, zero-padded string constants, and each is compared exactly.
  localparam logic [OPW-1:0] OpAdd  = OPW'("add");
  localparam logic [OPW-1:0] OpAnd  = OPW'("and");  // permanent alias of add
  localparam logic [OPW-1:0] OpSub  = OPW'("subtract");
  localparam logic [OPW-1:0] OpSubA = OPW'("subtract_a");
  localparam logic [OPW-1:0] OpOr   = OPW'("or_ab");
  localparam logic [OPW-1:0] OpAndL = OPW'("and_ab");
  localparam logic [OPW-1:0] OpNor  = OPW'("not_ab");
  localparam logic [OPW-1:0] OpXor  = OPW'("exor");
  localparam logic [OPW-1:0] OpXnor = OPW'("exnor");

  logic             arith;
  logic             err_d;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   arith_res;
  logic [WIDTH-1:0] sum_d;
  logic             c_d;

  // Subtraction reuses the adder: the subtrahend is inverted, and c_in supplies the +1.
  always_comb begin
    arith     = 1'b0;
    err_d     = 1'b0;
    op_x      = a;
    op_y      = b;
    logic_res = '0;
    case (oper)
      OpAdd, OpAnd: arith = 1'b1;
      OpSub: begin
        arith = 1'b1;
        op_y  = ~b;
      end
      OpSubA: begin
        arith = 1'b1;
        op_x  = b;
        op_y  = ~a;
      end
      OpOr:    logic_res = a | b;
      OpAndL:  logic_res = a & b;
      OpNor:   logic_res = ~(a | b);
      OpXor:   logic_res = a ^ b;
      OpXnor:  logic_res = ~(a ^ b);
      default: err_d = 1'b1;
    endcase
    arith_res = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, c_in};
    sum_d     = arith ? arith_res[WIDTH-1:0] : logic_res;
    c_d       = arith & arith_res[WIDTH];
  end

`ifdef ALU_FLAGS_EN
  logic ovf_d;

  // Overflow occurs when both adder inputs share a sign that differs from the result's sign.
  always_comb begin
    ovf_d = arith & (op_x[WIDTH-1] == op_y[WIDTH-1]) &
            (arith_res[WIDTH-1] != op_x[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      zero <= (sum_d == '0);
      neg  <= sum_d[WIDTH-1];
      ovf  <= ovf_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sum    <= '0;
      c_out  <= 1'b0;
      op_err <= 1'b0;
    end else begin
      sum    <= sum_d;
      c_out  <= c_d;
      op_err <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed self-checking bench for alu_8bit.
// Stimulus is applied on the falling edge and the results are sampled 1 ns after the rising edge.

module tb_alu_8bit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OPW   = 82;

  logic             clk = 1'b0;
  logic             rst;
  logic             c_out;
  logic [WIDTH-1:0] sum;
  logic             op_err;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif
  logic [OPW-1:0]   oper;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;

  int total = 0;
  int bad   = 0;

  alu_8bit #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .c_out (c_out),
    .sum   (sum),
    .op_err(op_err),
`ifdef ALU_FLAGS_EN
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf),
`endif
    .oper  (oper),
    .a     (a),
    .b     (b),
    .c_in  (c_in)
  );

  always #5 clk = ~clk;

  // Drive one operation and advance to just after the edge that captures it.
  task automatic run(input logic r, input logic [OPW-1:0] op, input logic [WIDTH-1:0] va,
                     input logic [WIDTH-1:0] vb, input logic vc);
    @(negedge clk);
    rst  = r;
    oper = op;
    a    = va;
    b    = vb;
    c_in = vc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] es, input logic ec,
                     input logic ee);
    total++;
    assert (sum === es) else begin
      bad++;
      $error("FAIL %s sum got=%h exp=%h", tag, sum, es);
    end
    total++;
    assert (c_out === ec) else begin
      bad++;
      $error("FAIL %s c_out got=%b exp=%b", tag, c_out, ec);
    end
    total++;
    assert (op_err === ee) else begin
      bad++;
      $error("FAIL %s op_err got=%b exp=%b", tag, op_err, ee);
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic chkf(input string tag, input logic ez, input logic en, input logic eo);
    total++;
    assert ({zero, neg, ovf} === {ez, en, eo}) else begin
      bad++;
      $error("FAIL %s flags(z,n,v) got=%b%b%b exp=%b%b%b", tag, zero, neg, ovf, ez, en, eo);
    end
  endtask
`endif

  initial begin
    rst  = 1'b1;
    oper = OPW'("add");
    a    = 8'h77;
    b    = 8'hD0;
    c_in = 1'b1;

    // 1. The reset is held for two edges, and the add op does not leak through.
    run(1'b1, OPW'("add"), 8'h77, 8'hD0, 1'b1);
    chk("reset1", 8'h00, 1'b0, 1'b0);
`ifdef ALU_FLAGS_EN
    chkf("reset1_flags", 1'b0, 1'b0, 1'b0);
`endif
    run(1'b1, OPW'("subtract"), 8'h77, 8'hD0, 1'b1);
    chk("reset2", 8'h00, 1'b0, 1'b0);
    run(1'b0, OPW'("add"), 8'h77, 8'hD0, 1'b1);
    chk("add", 8'h48, 1'b1, 1'b0);
`ifdef ALU_FLAGS_EN
    chkf("add_flags", 1'b0, 1'b0, 1'b0);
`endif

    // 2. Subtraction ops and the "and" alias (back-to-back, one op per cycle).
    run(1'b0, OPW'("subtract"), 8'h77, 8'hD0, 1'b1);
    chk("subtract", 8'hA7, 1'b0, 1'b0);
`ifdef ALU_FLAGS_EN
    chkf("subtract_flags", 1'b0, 1'b1, 1'b1);
`endif
    run(1'b0, OPW'("subtract_a"), 8'h77, 8'hD0, 1'b1);
    chk("subtract_a", 8'h59, 1'b1, 1'b0);
    run(1'b0, OPW'("and"), 8'h77, 8'hD0, 1'b1);
    chk("and_alias", 8'h48, 1'b1, 1'b0);
    run(1'b0, OPW'("add"), 8'h77, 8'hD0, 1'b0);
    chk("add_cin0", 8'h47, 1'b1, 1'b0);

    // 3. Logic ops, each of which must clear c_out.
    run(1'b0, OPW'("or_ab"), 8'h77, 8'hD0, 1'b1);
    chk("or_ab", 8'hF7, 1'b0, 1'b0);
    run(1'b0, OPW'("and_ab"), 8'h77, 8'hD0, 1'b1);
    chk("and_ab", 8'h50, 1'b0, 1'b0);
    run(1'b0, OPW'("not_ab"), 8'h77, 8'hD0, 1'b1);
    chk("not_ab", 8'h08, 1'b0, 1'b0);
    run(1'b0, OPW'("exor"), 8'h77, 8'hD0, 1'b1);
    chk("exor", 8'hA7, 1'b0, 1'b0);
    run(1'b0, OPW'("exnor"), 8'h77, 8'hD0, 1'b1);
    chk("exnor", 8'h58, 1'b0, 1'b0);

    // 4. A reset asserted mid-stream overrides the pending op, and the stream then resumes.
    run(1'b1, OPW'("add"), 8'h77, 8'hD0, 1'b1);
    chk("midreset", 8'h00, 1'b0, 1'b0);
    run(1'b0, OPW'("subtract_a"), 8'h77, 8'hD0, 1'b1);
    chk("after_reset", 8'h59, 1'b1, 1'b0);

    // 5. Unknown opcodes, including near-misses of legal opcodes.
    run(1'b0, OPW'("bogus"), 8'h77, 8'hD0, 1'b1);
    chk("bogus", 8'h00, 1'b0, 1'b1);
    run(1'b0, '0, 8'h77, 8'hD0, 1'b1);
    chk("zero_op", 8'h00, 1'b0, 1'b1);
    run(1'b0, OPW'("ADD"), 8'h77, 8'hD0, 1'b1);
    chk("upper_add", 8'h00, 1'b0, 1'b1);
    run(1'b0, OPW'("add") | (82'b1 << 81), 8'h77, 8'hD0, 1'b1);
    chk("spare_bit", 8'h00, 1'b0, 1'b1);
    // A reset also clears a pending op_err.
    run(1'b1, OPW'("bogus"), 8'h77, 8'hD0, 1'b1);
    chk("reset_err", 8'h00, 1'b0, 1'b0);

`ifdef ALU_FLAGS_EN
    run(1'b0, OPW'("add"), 8'h7F, 8'h01, 1'b0);
    chk("ovf_add", 8'h80, 1'b0, 1'b0);
    chkf("ovf_add_flags", 1'b0, 1'b1, 1'b1);
    run(1'b0, OPW'("subtract"), 8'h5A, 8'h5A, 1'b1);
    chk("sub_zero", 8'h00, 1'b1, 1'b0);
    chkf("sub_zero_flags", 1'b1, 1'b0, 1'b0);
    run(1'b0, OPW'("or_ab"), 8'h80, 8'h00, 1'b0);
    chkf("logic_flags", 1'b0, 1'b1, 1'b0);
    run(1'b0, OPW'("bogus"), 8'h7F, 8'h01, 1'b0);
    chkf("bogus_flags", 1'b1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
